// File: rtl/tdc_timestamp_packer.sv
// -----------------------------------------------------------------------------
// tdc_timestamp_packer
//
// Purpose:
//   Tags each fine code from the thermometer encoder with a free-running coarse
//   cycle counter. Buffers the {coarse, fine} words in a small FIFO. Presents
//   them to readout on a registered first-word-fall-through valid/ready port.
//   Hits that cannot be stored are counted as lost.
//
// Ports:
//   clk          single system clock, rising edge
//   rst          synchronous reset, active-high, highest priority
//   en           acquisition enable; runs the coarse counter and accepts hits
//   hit_valid    one-cycle hit strobe, qualifies fine_code
//   fine_code    binary fine time from the encoder
//   ts_data      oldest stored timestamp {coarse, fine}
//   ts_valid     ts_data holds a valid entry
//   ts_ready     consumer accepts ts_data when ts_valid && ts_ready
//   fifo_count   number of stored entries
//   overflow     sticky flag: at least one hit was dropped
//   lost_count   dropped-hit count, saturating at 255
//   clr_overflow one-cycle pulse that clears overflow and lost_count
// -----------------------------------------------------------------------------
module tdc_timestamp_packer #(
    parameter int COARSE_WIDTH = 16,
    parameter int FINE_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               hit_valid,
    input  logic [FINE_WIDTH-1:0]              fine_code,
    output logic [COARSE_WIDTH+FINE_WIDTH-1:0] ts_data,
    output logic                               ts_valid,
    input  logic                               ts_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               overflow,
    output logic [7:0]                         lost_count,
    input  logic                               clr_overflow
);

    localparam int TS_W  = COARSE_WIDTH + FINE_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // State
    logic [COARSE_WIDTH-1:0] coarse_q, coarse_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q,  count_d;
    logic [TS_W-1:0]         ts_data_q, ts_data_d;
    logic                    ts_valid_q, ts_valid_d;
    logic                    overflow_q, overflow_d;
    logic [7:0]              lost_q, lost_d;
    logic [TS_W-1:0]         mem_q [FIFO_DEPTH];

    // Per-edge events
    logic            push_req;
    logic            push;
    logic            pop;
    logic            drop;
    logic            full;
    logic [TS_W-1:0] hit_word;

    // NOTE: every signal assigned in always_comb gets a default at the top of
    // the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        coarse_d   = coarse_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ts_data_d  = ts_data_q;
        ts_valid_d = ts_valid_q;
        overflow_d = overflow_q;
        lost_d     = lost_q;

        // Counter is parked at 0 while disabled, so every enable restarts at 0.
        coarse_d = en ? coarse_q + COARSE_WIDTH'(1) : '0;

        // Captured coarse value is the pre-increment one.
        hit_word = {coarse_q, fine_code};
        push_req = en & hit_valid;
        pop      = ts_valid_q & ts_ready;
        full     = (count_q == DEPTH_C);
        // A full FIFO still takes the hit if a slot frees on the same edge.
        push     = push_req & (~full | pop);
        drop     = push_req & ~push;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Registered FWFT head. After the edge the head sits at rd_ptr_d.
        // The word being written this edge is the head only when it lands
        // on rd_ptr_d, i.e. it becomes the sole entry. It is not in the
        // array yet, so it is bypassed. With nothing stored, the head holds.
        ts_valid_d = (count_d != '0);
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) ts_data_d = hit_word;
            else                                ts_data_d = mem_q[rd_ptr_d];
        end

        // A drop on the same edge as a clear wins: the flag stays set and
        // the count restarts at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)        lost_d = 8'd1;
            else if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            lost_d     = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_data_q  <= '0;
            ts_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            lost_q     <= 8'd0;
        end else begin
            coarse_q   <= coarse_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ts_data_q  <= ts_data_d;
            ts_valid_q <= ts_valid_d;
            overflow_q <= overflow_d;
            lost_q     <= lost_d;
        end
    end

    // NOTE: the storage array has no reset. Emptiness is tracked by count_q,
    // so stale contents are never presented, and the array maps onto plain
    // RAM/register cells without a reset tree.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= hit_word;
    end

    assign ts_data    = ts_data_q;
    assign ts_valid   = ts_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign lost_count = lost_q;

endmodule

// File: tb/tb_tdc_timestamp_packer.sv
// -----------------------------------------------------------------------------
// tb_tdc_timestamp_packer
//
// Directed bench for tdc_timestamp_packer with default parameters
// (16-bit coarse, 5-bit fine, 8-deep FIFO). Inputs change 1 ns after a rising
// edge. Outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_tdc_timestamp_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        hit_valid = 1'b0;
    logic [4:0]  fine_code = '0;
    logic [20:0] ts_data;
    logic        ts_valid;
    logic        ts_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  lost_count;
    logic        clr_overflow = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Coarse counter reference: value the DUT counter holds before the next edge.
    logic [15:0] mdl_coarse = '0;
    logic [20:0] exp_q [9];
    logic [20:0] held;

    tdc_timestamp_packer #(
        .COARSE_WIDTH (16),
        .FINE_WIDTH   (5),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hit_valid    (hit_valid),
        .fine_code    (fine_code),
        .ts_data      (ts_data),
        .ts_valid     (ts_valid),
        .ts_ready     (ts_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .lost_count   (lost_count),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One rising edge, then advance 1 ns into the cycle.
    task automatic tick();
        @(posedge clk);
        if (rst)     mdl_coarse = '0;
        else if (en) mdl_coarse = mdl_coarse + 16'd1;
        else         mdl_coarse = '0;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        rst = 1'b0;
        check("rst_valid",    32'(ts_valid),   32'd0);
        check("rst_data",     32'(ts_data),    32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_lost",     32'(lost_count), 32'd0);

        // ---------------- 1: single hit at coarse 5 ----------------
        en = 1'b1;
        ts_ready = 1'b1;
        repeat (5) tick();
        hit_valid = 1'b1;
        fine_code = 5'd17;
        tick();
        hit_valid = 1'b0;
        check("t1_valid", 32'(ts_valid),   32'd1);
        check("t1_data",  32'(ts_data),    32'({16'd5, 5'd17}));
        check("t1_count", 32'(fifo_count), 32'd1);
        tick();
        check("t1_popped_valid", 32'(ts_valid),   32'd0);
        check("t1_popped_count", 32'(fifo_count), 32'd0);

        // ---------------- 2: overflow with 10 hits into 8 slots ----------------
        ts_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            hit_valid = 1'b1;
            fine_code = 5'(i);
            if (i < 8) exp_q[i] = {mdl_coarse, 5'(i)};
            tick();
        end
        hit_valid = 1'b0;
        check("t2_count",    32'(fifo_count), 32'd8);
        check("t2_overflow", 32'(overflow),   32'd1);
        check("t2_lost",     32'(lost_count), 32'd2);
        check("t2_head",     32'(ts_data),    32'(exp_q[0]));
        check("t2_head_fine", 32'(ts_data[4:0]), 32'd0);
        held = ts_data;
        repeat (2) tick();
        check("t2_stall_valid", 32'(ts_valid), 32'd1);
        check("t2_stall_data",  32'(ts_data),  32'(held));

        // ---------------- 3: push into full FIFO with simultaneous pop ----------------
        hit_valid = 1'b1;
        fine_code = 5'd10;
        ts_ready  = 1'b1;
        exp_q[8]  = {mdl_coarse, 5'd10};
        tick();
        hit_valid = 1'b0;
        check("t3_count",    32'(fifo_count), 32'd8);
        check("t3_overflow", 32'(overflow),   32'd1);
        check("t3_lost",     32'(lost_count), 32'd2);

        // Drain: fine 1..7 then the word accepted in test 3, one per cycle.
        for (int i = 1; i < 9; i++) begin
            check($sformatf("t2_drain%0d_valid", i), 32'(ts_valid), 32'd1);
            check($sformatf("t2_drain%0d_data", i),  32'(ts_data),  32'(exp_q[i]));
            tick();
        end
        check("t2_empty_valid", 32'(ts_valid),   32'd0);
        check("t2_empty_count", 32'(fifo_count), 32'd0);

        // ---------------- 4: coarse wrap and restart ----------------
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (65538) tick();
        hit_valid = 1'b1;
        fine_code = 5'd3;
        tick();
        hit_valid = 1'b0;
        check("t4_wrap_valid", 32'(ts_valid), 32'd1);
        check("t4_wrap_data",  32'(ts_data),  32'({16'd2, 5'd3}));
        en = 1'b0;
        tick();
        check("t4_drained", 32'(ts_valid), 32'd0);
        en = 1'b1;
        hit_valid = 1'b1;
        fine_code = 5'd7;
        tick();
        hit_valid = 1'b0;
        check("t4_restart_data", 32'(ts_data), 32'({16'd0, 5'd7}));
        tick();
        check("t4_restart_drained", 32'(ts_valid), 32'd0);

        // ---------------- 5: lost-count saturation and clear ----------------
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t5_clr0_overflow", 32'(overflow),   32'd0);
        check("t5_clr0_lost",     32'(lost_count), 32'd0);
        ts_ready  = 1'b0;
        hit_valid = 1'b1;
        repeat (308) tick();
        hit_valid = 1'b0;
        check("t5_sat_count",    32'(fifo_count), 32'd8);
        check("t5_sat_overflow", 32'(overflow),   32'd1);
        check("t5_sat_lost",     32'(lost_count), 32'd255);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t5_clr_overflow", 32'(overflow),   32'd0);
        check("t5_clr_lost",     32'(lost_count), 32'd0);
        clr_overflow = 1'b1;
        hit_valid    = 1'b1;
        tick();
        clr_overflow = 1'b0;
        hit_valid    = 1'b0;
        check("t5_race_overflow", 32'(overflow),   32'd1);
        check("t5_race_lost",     32'(lost_count), 32'd1);
        check("t5_race_count",    32'(fifo_count), 32'd8);

        // ---------------- 6: reset with entries stored ----------------
        ts_ready = 1'b1;
        repeat (4) tick();
        check("t6_pre_count", 32'(fifo_count), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid",    32'(ts_valid),   32'd0);
        check("t6_count",    32'(fifo_count), 32'd0);
        check("t6_data",     32'(ts_data),    32'd0);
        check("t6_overflow", 32'(overflow),   32'd0);
        check("t6_lost",     32'(lost_count), 32'd0);
        hit_valid = 1'b1;
        fine_code = 5'd9;
        tick();
        hit_valid = 1'b0;
        check("t6_first_data",  32'(ts_data),    32'({16'd0, 5'd9}));
        check("t6_first_count", 32'(fifo_count), 32'd1);
        tick();
        check("t6_no_stale_valid", 32'(ts_valid),   32'd0);
        check("t6_no_stale_count", 32'(fifo_count), 32'd0);
        tick();
        check("t6_still_empty", 32'(ts_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
